// File: rtl/memory_stage.sv
// EX/MEM pipeline register plus data-memory access unit: one req/ack transaction
// per load/store, store lane alignment and load extension.
module memory_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic [2:0]      Funct3E,
    input  logic [4:0]      RdE,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic [XLEN-1:0] WriteDataE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic            FlushM,
    output logic            RegWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [XLEN-1:0] ReadDataM,
    output logic            BusyM,
    output logic            FaultM,
    output logic            DMemReq,
    output logic            DMemWe,
    output logic [XLEN-1:0] DMemAddr,
    output logic [3:0]      DMemBe,
    output logic [XLEN-1:0] DMemWData,
    input  logic            DMemAck,
    input  logic [XLEN-1:0] DMemRData
);
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

    state_e          state_q, state_d;
    logic            regwrite_q, memwrite_q, fault_q;
    logic [1:0]      resultsrc_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] alu_q, wdata_q, pc4_q, rdata_q;

    logic            memop_e, misalign_e, fault_e, access_c;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] load_ext, store_data;
    logic [3:0]      store_be;

    // Classify the incoming Execute op; illegal sizes count as misaligned.
    always_comb begin
        memop_e = MemWriteE || (ResultSrcE == 2'b01);
        case (Funct3E)
            3'b000, 3'b100: misalign_e = 1'b0;
            3'b001, 3'b101: misalign_e = ALUResultE[0];
            3'b010:         misalign_e = |ALUResultE[1:0];
            default:        misalign_e = 1'b1;
        endcase
        fault_e = memop_e && misalign_e;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!FlushM && memop_e && !fault_e) state_d = ACCESS;
            ACCESS:  if (DMemAck) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign access_c = (state_q == ACCESS);

    // M register: captures only while idle, so an outstanding access holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            fault_q     <= 1'b0;
            resultsrc_q <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            alu_q       <= '0;
            wdata_q     <= '0;
            pc4_q       <= '0;
        end else if (!access_c) begin
            if (FlushM) begin
                regwrite_q  <= 1'b0;
                memwrite_q  <= 1'b0;
                fault_q     <= 1'b0;
                resultsrc_q <= '0;
                funct3_q    <= '0;
                rd_q        <= '0;
                alu_q       <= '0;
                wdata_q     <= '0;
                pc4_q       <= '0;
            end else begin
                regwrite_q  <= RegWriteE && !fault_e;
                memwrite_q  <= MemWriteE;
                fault_q     <= fault_e;
                resultsrc_q <= ResultSrcE;
                funct3_q    <= Funct3E;
                rd_q        <= RdE;
                alu_q       <= ALUResultE;
                wdata_q     <= WriteDataE;
                pc4_q       <= PCPlus4E;
            end
        end
    end

    // Load lane select and extension from the acknowledged read word.
    always_comb begin
        lane_b = DMemRData[{alu_q[1:0], 3'b000} +: 8];
        lane_h = alu_q[1] ? DMemRData[31:16] : DMemRData[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{(XLEN-8){lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{(XLEN-16){lane_h[15]}}, lane_h};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, lane_b};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, lane_h};
            default: load_ext = DMemRData;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              rdata_q <= '0;
        else if (access_c && DMemAck && !memwrite_q) rdata_q <= load_ext;
    end

    // Store lane placement; enables only asserted for an active write.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                store_be   = 4'(4'b0001 << alu_q[1:0]);
                store_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                store_be   = alu_q[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata_q[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = wdata_q;
            end
        endcase
        if (!(access_c && memwrite_q)) store_be = 4'b0000;
    end

    assign RegWriteM  = regwrite_q;
    assign ResultSrcM = resultsrc_q;
    assign RdM        = rd_q;
    assign ALUResultM = alu_q;
    assign PCPlus4M   = pc4_q;
    assign ReadDataM  = rdata_q;
    assign FaultM     = fault_q;
    assign BusyM      = access_c;
    assign DMemReq    = access_c;
    assign DMemWe     = access_c && memwrite_q;
    assign DMemAddr   = {alu_q[XLEN-1:2], 2'b00};
    assign DMemBe     = store_be;
    assign DMemWData  = store_data;
endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios then random traffic
// against a behavioural model of alignment, faults and load extension.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RegWriteE, MemWriteE, FlushM, DMemAck;
    logic [1:0]  ResultSrcE;
    logic [2:0]  Funct3E;
    logic [4:0]  RdE;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E, DMemRData;
    logic        RegWriteM, BusyM, FaultM, DMemReq, DMemWe;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, PCPlus4M, ReadDataM, DMemAddr, DMemWData;
    logic [3:0]  DMemBe;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] exp_rdata = 32'h0;

    memory_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .Funct3E(Funct3E), .RdE(RdE), .ALUResultE(ALUResultE),
        .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .FlushM(FlushM),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
        .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M), .ReadDataM(ReadDataM),
        .BusyM(BusyM), .FaultM(FaultM), .DMemReq(DMemReq), .DMemWe(DMemWe),
        .DMemAddr(DMemAddr), .DMemBe(DMemBe), .DMemWData(DMemWData),
        .DMemAck(DMemAck), .DMemRData(DMemRData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: natural size is 1 << (f3 % 4); sizes 3,6,7 are illegal.
    function automatic logic m_fault(input int unsigned f3, input logic [31:0] a);
        int unsigned size;
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        size = 32'd1 << (f3 % 4);
        return (a % size) != 0;
    endfunction

    function automatic logic [3:0] m_be(input int unsigned f3, input logic [31:0] a);
        case (f3 % 4)
            0:       return 4'(32'd1 << (a % 4));
            1:       return (a % 4 >= 2) ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input int unsigned f3, input logic [31:0] d);
        case (f3 % 4)
            0:       return (d & 32'hFF) * 32'h0101_0101;
            1:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input int unsigned f3, input logic [31:0] a,
                                           input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * (a % 4));
        case (f3)
            0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
            1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
            4: v = v & 32'hFF;
            5: v = v & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    // Drive one Execute op, follow it through M and check every cycle of occupancy.
    task automatic issue(input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pc, input logic flush,
                         input int waits, input logic [31:0] rdata, input string tag);
        logic memop, fault, e_rw;
        logic [1:0] e_rs;
        logic [4:0] e_rd;
        logic [31:0] e_alu, e_pc;
        RegWriteE = rw; MemWriteE = mw; ResultSrcE = rs; Funct3E = f3; RdE = rd;
        ALUResultE = alu; WriteDataE = wd; PCPlus4E = pc; FlushM = flush; DMemAck = 1'b0;
        chk({tag, ":busy_pre"}, 32'(BusyM), 32'h0);
        step();
        memop = !flush && (mw || rs == 2'b01);
        fault = memop && m_fault(32'(f3), alu);
        e_rw  = !flush && rw && !fault;
        e_rs  = flush ? 2'b00 : rs;
        e_rd  = flush ? 5'd0 : rd;
        e_alu = flush ? 32'h0 : alu;
        e_pc  = flush ? 32'h0 : pc;
        chk({tag, ":fault"}, 32'(FaultM), 32'(fault));
        chk({tag, ":regwrite"}, 32'(RegWriteM), 32'(e_rw));
        chk({tag, ":alures"}, ALUResultM, e_alu);
        if (memop && !fault) begin
            for (int i = 0; i <= waits; i++) begin
                chk({tag, ":busy"}, 32'(BusyM), 32'h1);
                chk({tag, ":req"}, 32'(DMemReq), 32'h1);
                chk({tag, ":we"}, 32'(DMemWe), 32'(mw));
                chk({tag, ":addr"}, DMemAddr, alu & 32'hFFFF_FFFC);
                chk({tag, ":be"}, 32'(DMemBe), mw ? 32'(m_be(32'(f3), alu)) : 32'h0);
                if (mw) chk({tag, ":wdata"}, DMemWData, m_wdata(32'(f3), wd));
                chk({tag, ":rd_hold"}, 32'(RdM), 32'(e_rd));
                // Execute keeps changing and flush is requested; neither may disturb M.
                RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
                ResultSrcE = 2'($urandom); Funct3E = 3'($urandom); RdE = 5'($urandom);
                ALUResultE = $urandom; WriteDataE = $urandom; PCPlus4E = $urandom;
                FlushM = 1'b1;
                DMemAck = (i == waits);
                DMemRData = (i == waits) ? rdata : $urandom;
                step();
            end
            DMemAck = 1'b0;
            if (!mw) exp_rdata = m_load(32'(f3), alu, rdata);
        end
        chk({tag, ":busy_post"}, 32'(BusyM), 32'h0);
        chk({tag, ":req_post"}, 32'(DMemReq), 32'h0);
        chk({tag, ":rdata"}, ReadDataM, exp_rdata);
        chk({tag, ":rs_hold"}, 32'(ResultSrcM), 32'(e_rs));
        chk({tag, ":rd_post"}, 32'(RdM), 32'(e_rd));
        chk({tag, ":pc_post"}, PCPlus4M, e_pc);
        chk({tag, ":alu_post"}, ALUResultM, e_alu);
        chk({tag, ":rw_post"}, 32'(RegWriteM), 32'(e_rw));
    endtask

    initial begin
        RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; Funct3E = 0; RdE = 0;
        ALUResultE = 0; WriteDataE = 0; PCPlus4E = 0; FlushM = 0;
        DMemAck = 0; DMemRData = 0;
        #3;
        chk("rst:regwrite", 32'(RegWriteM), 32'h0);
        chk("rst:alures", ALUResultM, 32'h0);
        chk("rst:rdata", ReadDataM, 32'h0);
        chk("rst:busy", 32'(BusyM), 32'h0);
        chk("rst:fault", 32'(FaultM), 32'h0);
        chk("rst:req", 32'(DMemReq), 32'h0);
        chk("rst:be", 32'(DMemBe), 32'h0);
        #4 rst_n = 1'b1;
        step();

        // LB with three wait states, then LBU of the same word.
        issue(1, 0, 2'b01, 3'b000, 5'd5, 32'h1003, 32'h0, 32'h40, 0, 3, 32'h80FF_FF11, "lb");
        chk("lb:value", ReadDataM, 32'hFFFF_FF80);
        issue(1, 0, 2'b01, 3'b100, 5'd6, 32'h1003, 32'h0, 32'h44, 0, 0, 32'h80FF_FF11, "lbu");
        chk("lbu:value", ReadDataM, 32'h0000_0080);

        // SH to upper half; check bus directly in the access cycle.
        RegWriteE = 0; MemWriteE = 1; ResultSrcE = 0; Funct3E = 3'b001; RdE = 0;
        ALUResultE = 32'h2002; WriteDataE = 32'hDEAD_BEEF; PCPlus4E = 32'h48; FlushM = 0;
        step();
        chk("sh:we", 32'(DMemWe), 32'h1);
        chk("sh:be", 32'(DMemBe), 32'hC);
        chk("sh:wdata", DMemWData, 32'hBEEF_BEEF);
        chk("sh:addr", DMemAddr, 32'h2000);
        DMemAck = 1'b1;
        step();
        DMemAck = 1'b0;
        chk("sh:busy_post", 32'(BusyM), 32'h0);

        issue(1, 0, 2'b01, 3'b010, 5'd7, 32'h6, 32'h0, 32'h4C, 0, 0, 32'h0, "lw_mis");
        issue(1, 0, 2'b01, 3'b011, 5'd8, 32'h8, 32'h0, 32'h50, 0, 0, 32'h0, "ld_ill");
        issue(1, 0, 2'b00, 3'b000, 5'd9, 32'h1234, 32'h0, 32'h54, 1, 0, 32'h0, "flush_idle");
        issue(1, 0, 2'b01, 3'b101, 5'd10, 32'h3002, 32'h0, 32'h58, 0, 2, 32'h9234_5678, "lhu_stall");

        // Back-to-back ADD, SW, LW with zero-wait ack.
        issue(1, 0, 2'b00, 3'b000, 5'd11, 32'hCAFE_0001, 32'h0, 32'h5C, 0, 0, 32'h0, "add");
        issue(0, 1, 2'b00, 3'b010, 5'd0, 32'h4000, 32'h1357_9BDF, 32'h60, 0, 0, 32'h0, "sw");
        issue(1, 0, 2'b01, 3'b010, 5'd12, 32'h4000, 32'h0, 32'h64, 0, 0, 32'h1357_9BDF, "lw");

        // Reset while an access is outstanding.
        RegWriteE = 1; MemWriteE = 0; ResultSrcE = 2'b01; Funct3E = 3'b010; RdE = 5'd13;
        ALUResultE = 32'h5000; FlushM = 0;
        step();
        chk("rstacc:req_before", 32'(DMemReq), 32'h1);
        chk("rstacc:rw_before", 32'(RegWriteM), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstacc:req", 32'(DMemReq), 32'h0);
        chk("rstacc:busy", 32'(BusyM), 32'h0);
        chk("rstacc:regwrite", 32'(RegWriteM), 32'h0);
        exp_rdata = 32'h0;
        RegWriteE = 0; ResultSrcE = 2'b00; RdE = 0; ALUResultE = 0; FlushM = 1;
        #1 rst_n = 1'b1;
        step();
        chk("rstacc:busy_after", 32'(BusyM), 32'h0);
        chk("rstacc:rdata_after", ReadDataM, 32'h0);

        // Random traffic.
        for (int n = 0; n < 120; n++) begin
            logic mw_r;
            logic [1:0] rs_r;
            mw_r = ($urandom_range(0, 9) < 3);
            rs_r = 2'($urandom);
            issue(1'($urandom), mw_r, rs_r, 3'($urandom), 5'($urandom),
                  32'($urandom) & 32'h0000_FFFF, $urandom, $urandom,
                  ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)), $urandom, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of Execute: EX/MEM pipeline register plus data-memory access unit.
- Captures ALU result, store data and control from Execute; issues one request/acknowledge transaction per load/store.
- Aligns store data and byte enables, sign/zero-extends load data.
- Raises BusyM so the hazard unit stalls the front of the pipeline while an access is outstanding; exports ALUResultM for Execute forwarding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- RegWriteE  input  1  register write enable from Execute
- MemWriteE  input  1  store indicator from Execute
- ResultSrcE  input  2  result select; 2'b01 marks a load
- Funct3E  input  3  access size/sign
- RdE  input  5  destination register
- ALUResultE  input  32  effective address / ALU result
- WriteDataE  input  32  forwarded store data
- PCPlus4E  input  32  link value
- FlushM  input  1  insert bubble instead of capturing Execute outputs
- RegWriteM  output  1  registered write enable, forced 0 on fault
- ResultSrcM  output  2  registered result select
- RdM  output  5  registered destination
- ALUResultM  output  32  registered ALU result; forwarding source
- PCPlus4M  output  32  registered link value
- ReadDataM  output  32  extended load data
- BusyM  output  1  access outstanding; stall request
- FaultM  output  1  misaligned or illegal-size access held in stage
- DMemReq  output  1  memory request
- DMemWe  output  1  1 = write, 0 = read
- DMemAddr  output  32  word-aligned address, {ALUResultM[31:2],2'b00}
- DMemBe  output  4  byte enables (writes only; 4'b0000 on reads)
- DMemWData  output  32  lane-aligned store data
- DMemAck  input  1  transaction complete; sampled only while DMemReq=1
- DMemRData  input  32  read word, valid in the DMemAck cycle

Behaviour:
- Reset (async, immediate): all M registers 0, FaultM=0, ReadDataM=0, state IDLE, DMemReq=0, BusyM=0.
- Capture: on each edge with BusyM=0, the M register loads E inputs. If FlushM=1, it loads a bubble instead: all controls 0, data 0.
- While BusyM=1, the M register holds and FlushM is ignored. An outstanding access always completes.
- Memory op = MemWriteE=1 or ResultSrcE=2'b01. Both set: treat as store.
- Fault conditions, evaluated at capture:
  - Funct3 in {011,110,111}.
  - Halfword access (Funct3 001 or 101) with addr[0]=1.
  - Word access (Funct3 010) with addr[1:0]!=0.
  - On fault: FaultM=1, RegWriteM=0, no request issued, state stays IDLE; one-cycle occupancy.
- Non-memory ops and faulted ops occupy M for one cycle; state stays IDLE.
- FSM: IDLE, ACCESS.
  - IDLE -> ACCESS on the capture edge of a valid (non-faulted) memory op.
  - ACCESS -> IDLE on the edge where DMemAck=1.
- In ACCESS:
  - DMemReq=1, BusyM=1.
  - DMemWe, DMemAddr, DMemBe, DMemWData are stable until the ack edge.
- BusyM = (state==ACCESS), combinational from state. Minimum memory-op occupancy is 2 cycles.
- Ack arriving in the same cycle as DMemReq first rises is legal.
- On the ack edge of a load, ReadDataM latches the extended data; it is valid from the following cycle until the next load completes.
- Store lanes:
  - SB: Be = 4'b0001 << addr[1:0]; WData = byte replicated ×4.
  - SH: Be = addr[1] ? 4'b1100 : 4'b0011; WData = halfword replicated ×2.
  - SW: Be = 4'b1111; WData = word.
- Load extension: select the lane by addr[1:0].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- Reset during ACCESS: DMemReq drops immediately, the transaction is abandoned, and the stage returns to IDLE.

Test Plan:
- Reset mid-ACCESS: rst_n low with DMemReq=1 -> DMemReq, BusyM, RegWriteM = 0 in the same cycle, without waiting for a clock edge; state IDLE after release.
- LB: ALUResultE=0x1003, Funct3=000, DMemRData=0x80FF_FF11, ack after 3 wait cycles.
  - BusyM=1 for 4 cycles; DMemAddr=0x1000; DMemBe=0.
  - ReadDataM=0xFFFF_FF80; LBU of the same word -> 0x0000_0080.
- SH: ALUResultE=0x2002, WriteDataE=0xDEAD_BEEF -> DMemWe=1, DMemBe=4'b1100, DMemWData=0xBEEF_BEEF, DMemAddr=0x2000.
- Misaligned LW: addr 0x0000_0006 -> DMemReq stays 0, FaultM=1, RegWriteM=0, BusyM=0, stage frees next cycle.
- Stall/flush interaction: FlushM=1 while BusyM=1 -> ignored; M contents unchanged through ack. FlushM=1 while IDLE -> bubble with RegWriteM=0.
- Back-to-back: ADD then SW then LW, all with zero-wait ack.
  - ADD: ALUResultM valid for 1 cycle.
  - SW, then LW: each occupies 2 cycles; BusyM pattern 0,1,0,1,0.
